// File: rtl/lcd_dma_pkg.sv
// lcd_dma_pkg
// Shared constants for the LCD read-DMA scheduler.
//  BURST_LEN       default maximum words per bus burst
//  FIFO_DEPTH      default pixel FIFO capacity in words
//  BYTES_PER_WORD  address stride of one bus word
//  dma_state_t     FSM state encoding, with ST_* state constants
package lcd_dma_pkg;

    localparam int BURST_LEN      = 8;
    localparam int FIFO_DEPTH     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [2:0] dma_state_t;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD       = 3'd1;
    localparam logic [2:0] ST_WAIT_SPACE = 3'd2;
    localparam logic [2:0] ST_REQ        = 3'd3;
    localparam logic [2:0] ST_DATA       = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

endpackage

// File: rtl/lcd_dma_sched.sv
// lcd_dma_sched
// Read-DMA scheduler that walks the frame buffer one burst at a time and
// pushes the returned words straight into the LCD pixel FIFO. A burst is only
// requested once the FIFO reports enough free entries for the whole burst.
// Ports:
//  clk, rst              clock and asynchronous active-high reset
//  enable                DMA enable level, honoured at burst boundaries
//  fb_base, fb_words     frame buffer base address and length in words
//  fp_pulse              frame pulse, restarts the walk at fb_base
//  depth_left            free FIFO entries
//  fifo_push, fifo_data  FIFO push side (combinational pass of read beats)
//  bus_req/addr/len/gnt  burst request handshake to the bus read master
//  bus_rvalid, bus_rdata read beats returned by the bus
//  busy                  high while a frame is being walked
//  frame_done            1-cycle pulse with the final push of a frame
module lcd_dma_sched #(
    parameter int ADDR_W     = 32,
    parameter int BURST_LEN  = lcd_dma_pkg::BURST_LEN,
    parameter int FIFO_DEPTH = lcd_dma_pkg::FIFO_DEPTH,
    parameter int LEN_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [LEN_W-1:0]  fb_words,
    input  logic              fp_pulse,
    input  logic [5:0]        depth_left,
    output logic              fifo_push,
    output logic [31:0]       fifo_data,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_len,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output logic              busy,
    output logic              frame_done
);
    import lcd_dma_pkg::*;

    localparam int BEAT_W = 4;

    dma_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [BEAT_W-1:0] beat_cnt;
    logic              restart_pend;

    logic [3:0]        len;
    logic              last_beat;
    logic              take_restart;
    logic              frame_end;

    // Size of the next burst: a full burst, or whatever is left of the frame.
    // remaining does not move between WAIT_SPACE and the last beat, so len
    // stays stable for the request and for the end-of-burst bookkeeping.
    always_comb begin
        len = 4'(BURST_LEN);
        if (remaining < LEN_W'(BURST_LEN)) begin
            len = remaining[3:0];
        end
    end

    // A frame pulse arriving on the very last beat restarts just like one
    // that arrived earlier in the burst.
    assign last_beat    = (state == ST_DATA) && bus_rvalid && (beat_cnt == BEAT_W'(1));
    assign take_restart = restart_pend || fp_pulse;
    assign frame_end    = last_beat && !take_restart && enable
                          && (remaining == LEN_W'(len));

    assign bus_req    = (state == ST_REQ);
    assign bus_addr   = bus_req ? addr : '0;
    assign bus_len    = bus_req ? len : 4'd0;
    assign fifo_push  = (state == ST_DATA) && bus_rvalid;
    assign fifo_data  = fifo_push ? bus_rdata : 32'd0;
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign frame_done = frame_end;

    // Scheduler FSM with address, length and beat bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            remaining    <= '0;
            beat_cnt     <= '0;
            restart_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    addr         <= fb_base & ~ADDR_W'(BYTES_PER_WORD - 1);
                    remaining    <= fb_words;
                    beat_cnt     <= '0;
                    restart_pend <= 1'b0;
                    state        <= (fb_words == '0) ? ST_DONE : ST_WAIT_SPACE;
                end
                ST_WAIT_SPACE: begin
                    if (fp_pulse) begin
                        state <= ST_LOAD;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end else if (depth_left >= {2'b00, len}) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant commits the burst even if a frame pulse lands
                    // in the same cycle; the restart is deferred until the
                    // burst has drained.
                    if (bus_gnt) begin
                        state        <= ST_DATA;
                        beat_cnt     <= BEAT_W'(len);
                        restart_pend <= fp_pulse;
                    end else if (fp_pulse) begin
                        state <= ST_LOAD;
                    end
                end
                ST_DATA: begin
                    if (fp_pulse) begin
                        restart_pend <= 1'b1;
                    end
                    if (bus_rvalid) begin
                        beat_cnt <= beat_cnt - BEAT_W'(1);
                        if (beat_cnt == BEAT_W'(1)) begin
                            addr      <= addr + ADDR_W'(len) * ADDR_W'(BYTES_PER_WORD);
                            remaining <= remaining - LEN_W'(len);
                            if (take_restart) begin
                                state <= ST_LOAD;
                            end else if (!enable) begin
                                state <= ST_IDLE;
                            end else if (remaining == LEN_W'(len)) begin
                                state <= ST_DONE;
                            end else begin
                                state <= ST_WAIT_SPACE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (fp_pulse) begin
                        state <= ST_LOAD;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Safety properties: no push into a full FIFO, a pending request keeps
    // its address and length until granted (unless a frame pulse abandons
    // it), and the beat counter never exceeds one burst.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && depth_left == 6'd0));

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (bus_req && !bus_gnt && !fp_pulse) |=>
        (bus_req && $stable(bus_addr) && $stable(bus_len)));

    a_beat_bound: assert property (@(posedge clk) disable iff (rst)
        beat_cnt <= BEAT_W'(BURST_LEN));

    a_depth_range: assert property (@(posedge clk) disable iff (rst)
        depth_left <= 6'(FIFO_DEPTH));

endmodule

// File: tb/tb_lcd_dma_sched.sv
// tb_lcd_dma_sched
// Directed bench for lcd_dma_sched. Inputs change on the falling clock edge
// and outputs are sampled 1 time unit later, so the rising edge never races
// with either. A small bus responder task grants each request one cycle after
// it appears and returns one beat per cycle.
module tb_lcd_dma_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] fb_base;
    logic [19:0] fb_words;
    logic        fp_pulse;
    logic [5:0]  depth_left;
    logic        fifo_push;
    logic [31:0] fifo_data;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_len;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        frame_done;

    int n_pass  = 0;
    int n_total = 0;
    int pushes  = 0;
    int dones   = 0;

    lcd_dma_sched dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fb_base    (fb_base),
        .fb_words   (fb_words),
        .fp_pulse   (fp_pulse),
        .depth_left (depth_left),
        .fifo_push  (fifo_push),
        .fifo_data  (fifo_data),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_len    (bus_len),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running totals of pushes and frame_done pulses, sampled mid-cycle.
    always begin
        @(negedge clk);
        #1;
        if (fifo_push === 1'b1) pushes++;
        if (frame_done === 1'b1) dones++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_total++;
        assert (obs === exp_val) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_val);
    endtask

    // Waits (bounded) for a request, checks it, grants it one cycle later and
    // returns exp_len beats. Optional events by beat index (-1 = none): frame
    // pulse, enable drop, or reset assertion (task returns with rst held).
    task automatic run_burst(input string tag, input logic [31:0] exp_addr, input int exp_len,
                             input bit exp_done, input int fp_beat, input bit fp_gnt,
                             input int en_off_beat, input int rst_beat);
        int waited;
        logic [31:0] word;
        waited = 0;
        #1;
        while (bus_req !== 1'b1 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, " req"}, 32'(bus_req), 32'd1);
        check({tag, " addr"}, bus_addr, exp_addr);
        check({tag, " len"}, 32'(bus_len), 32'(exp_len));
        check({tag, " busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        bus_gnt    = 1'b1;
        fp_pulse   = fp_gnt;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0_BAD0;
        #1;
        check({tag, " req held"}, 32'(bus_req), 32'd1);
        check({tag, " addr held"}, bus_addr, exp_addr);
        check({tag, " stray rvalid in REQ"}, 32'(fifo_push), 32'd0);
        @(negedge clk);
        bus_gnt    = 1'b0;
        fp_pulse   = 1'b0;
        bus_rvalid = 1'b0;
        for (int i = 0; i < exp_len; i++) begin
            word       = 32'hD000_0000 ^ (exp_addr + 32'(4 * i));
            bus_rvalid = 1'b1;
            bus_rdata  = word;
            fp_pulse   = (i == fp_beat);
            if (i == en_off_beat) enable = 1'b0;
            if (i == rst_beat) begin
                rst = 1'b1;
                #1;
                check({tag, " push in reset"}, 32'(fifo_push), 32'd0);
                check({tag, " busy in reset"}, 32'(busy), 32'd0);
                check({tag, " data in reset"}, fifo_data, 32'd0);
                fp_pulse = 1'b0;
                return;
            end
            #1;
            check($sformatf("%s push%0d", tag, i), 32'(fifo_push), 32'd1);
            check($sformatf("%s data%0d", tag, i), fifo_data, word);
            check($sformatf("%s done%0d", tag, i), 32'(frame_done),
                  32'(exp_done && (i == exp_len - 1)));
            @(negedge clk);
            bus_rvalid = 1'b0;
            fp_pulse   = 1'b0;
        end
    endtask

    // Drives a one-cycle frame pulse with new frame parameters.
    task automatic frame_pulse(input logic [31:0] base, input logic [19:0] words);
        fb_base  = base;
        fb_words = words;
        fp_pulse = 1'b1;
        @(negedge clk);
        fp_pulse = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        fb_base    = 32'd0;
        fb_words   = 20'd0;
        fp_pulse   = 1'b0;
        depth_left = 6'd32;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_len", 32'(bus_len), 32'd0);
        check("reset fifo_push", 32'(fifo_push), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);

        // 1: 20-word frame -> bursts of 8, 8, 4 then DONE.
        @(negedge clk);
        rst      = 1'b0;
        enable   = 1'b1;
        fb_base  = 32'h0000_1000;
        fb_words = 20'd20;
        run_burst("t1b0", 32'h0000_1000, 8, 1'b0, -1, 1'b0, -1, -1);
        run_burst("t1b1", 32'h0000_1020, 8, 1'b0, -1, 1'b0, -1, -1);
        run_burst("t1b2", 32'h0000_1040, 4, 1'b1, -1, 1'b0, -1, -1);
        #1;
        check("t1 busy in DONE", 32'(busy), 32'd0);
        check("t1 pushes", 32'(pushes), 32'd20);
        check("t1 frame_done count", 32'(dones), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t1 no req in DONE", 32'(bus_req), 32'd0);
        end

        // 2: too little FIFO space holds the request back.
        @(negedge clk);
        depth_left = 6'd5;
        frame_pulse(32'h0000_2000, 20'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t2 no req while short", 32'(bus_req), 32'd0);
            check("t2 busy while short", 32'(busy), 32'd1);
        end
        @(negedge clk);
        depth_left = 6'd8;
        #1;
        check("t2 req not yet", 32'(bus_req), 32'd0);
        @(negedge clk);
        #1;
        check("t2 req after space", 32'(bus_req), 32'd1);
        run_burst("t2b0", 32'h0000_2000, 8, 1'b1, -1, 1'b0, -1, -1);
        #1;
        check("t2 pushes", 32'(pushes), 32'd28);

        // 3: frame pulse on the third beat finishes the burst, then restarts.
        @(negedge clk);
        depth_left = 6'd32;
        frame_pulse(32'h0000_3000, 20'd16);
        run_burst("t3b0", 32'h0000_3000, 8, 1'b0, 2, 1'b0, -1, -1);
        #1;
        check("t3 busy in LOAD", 32'(busy), 32'd1);
        check("t3 no req in LOAD", 32'(bus_req), 32'd0);
        run_burst("t3r0", 32'h0000_3000, 8, 1'b0, -1, 1'b0, -1, -1);
        run_burst("t3r1", 32'h0000_3020, 8, 1'b1, -1, 1'b0, -1, -1);
        #1;
        check("t3 pushes", 32'(pushes), 32'd52);
        check("t3 frame_done count", 32'(dones), 32'd3);

        // 4: enable dropped on beat 2 lets the burst finish, then IDLE.
        @(negedge clk);
        frame_pulse(32'h0000_4000, 20'd16);
        run_burst("t4b0", 32'h0000_4000, 8, 1'b0, -1, 1'b0, 1, -1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4 idle busy", 32'(busy), 32'd0);
            check("t4 idle req", 32'(bus_req), 32'd0);
            @(negedge clk);
        end
        check("t4 pushes", 32'(pushes), 32'd60);

        // 5a: zero-length frame goes LOAD -> DONE without a request.
        fb_base  = 32'h0000_5000;
        fb_words = 20'd0;
        enable   = 1'b1;
        @(negedge clk);
        #1;
        check("t5 busy in LOAD", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t5 empty busy", 32'(busy), 32'd0);
            check("t5 empty req", 32'(bus_req), 32'd0);
        end
        check("t5 frame_done count", 32'(dones), 32'd3);

        // 5b: reset in the middle of a burst, then stray beats are dropped.
        @(negedge clk);
        frame_pulse(32'h0000_5000, 20'd8);
        run_burst("t5b0", 32'h0000_5000, 8, 1'b0, -1, 1'b0, -1, 3);
        @(negedge clk);
        #1;
        check("t5 push held in reset", 32'(fifo_push), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5 stray rvalid", 32'(fifo_push), 32'd0);
            check("t5 busy after reset", 32'(busy), 32'd0);
            @(negedge clk);
        end
        bus_rvalid = 1'b0;
        check("t5 pushes", 32'(pushes), 32'd63);

        // 6: frame pulse together with the grant keeps the burst, then restarts.
        enable   = 1'b1;
        fb_base  = 32'h0000_6000;
        fb_words = 20'd16;
        run_burst("t6b0", 32'h0000_6000, 8, 1'b0, -1, 1'b1, -1, -1);
        run_burst("t6r0", 32'h0000_6000, 8, 1'b0, -1, 1'b0, -1, -1);
        run_burst("t6r1", 32'h0000_6020, 8, 1'b1, -1, 1'b0, -1, -1);
        #1;
        check("t6 pushes", 32'(pushes), 32'd87);
        check("t6 frame_done count", 32'(dones), 32'd4);
        check("t6 busy in DONE", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
